icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the pipelined CPU instruction port (inst_addr / inst_mem) and a slower backing instruction memory.
- Hits return the instruction combinationally in the same cycle, matching the CPU's same-cycle fetch.
- Misses raise a stall (CPU holds PC, IF/ID receives NOP) while a refill FSM fetches the whole line word-by-word over a req/ack handshake.

---
 rtl/icache_dm_pkg.sv | 15 +
 rtl/icache_tag_store.sv | 44 ++++
 rtl/icache_dm.sv | 139 +++++++++++++
 tb/tb_icache_dm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// default geometry, refill FSM state encoding and the NOP word.
package icache_dm_pkg;

   localparam int DEF_INDEX_BITS = 6;
   localparam int DEF_WORD_BITS  = 2;

   localparam logic [31:0] NOP = 32'h0;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_REFILL = 1'b1
   } state_e;

endpackage

// File: rtl/icache_tag_store.sv
// Valid bits and tags for the direct-mapped cache, plus the indexed compare.
// Ports: clk_i, rst_i (sync, active-high), en_i (lookup enable),
//   idx_i/tag_i (lookup), clr_en_i (invalidate idx_i),
//   set_en_i/set_idx_i/set_tag_i (write tag, mark valid), hit_o.
module icache_tag_store
   import icache_dm_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int TAG_BITS   = 32 - DEF_INDEX_BITS - DEF_WORD_BITS - 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [INDEX_BITS-1:0] idx_i,
   input  logic [TAG_BITS-1:0]   tag_i,
   input  logic                  clr_en_i,
   input  logic                  set_en_i,
   input  logic [INDEX_BITS-1:0] set_idx_i,
   input  logic [TAG_BITS-1:0]   set_tag_i,
   output logic                  hit_o
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q [LINES];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else begin
         if (clr_en_i) valid_q[idx_i]     <= 1'b0;
         if (set_en_i) valid_q[set_idx_i] <= 1'b1;
      end
   end

   // Tag contents are don't-care while the valid bit is low.
   always_ff @(posedge clk_i) begin
      if (set_en_i) tag_q[set_idx_i] <= set_tag_i;
   end

   assign hit_o = en_i && valid_q[idx_i] && (tag_q[idx_i] == tag_i);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
// Ports: clk, rst (sync, active-high); CPU side cpu_addr/cpu_inst/cpu_stall;
//   memory side mem_req/mem_addr/mem_rdata/mem_ack; stat_hits/stat_misses.
// Optional: define ICACHE_STATS_EN to enable the hit/miss counters.
module icache_dm
   import icache_dm_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int WORD_BITS  = DEF_WORD_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   output logic [31:0] cpu_inst,
   output logic        cpu_stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] stat_hits,
   output logic [31:0] stat_misses
);

   localparam int TAG_BITS  = 32 - INDEX_BITS - WORD_BITS - 2;
   localparam int LINE_BITS = 32 - WORD_BITS - 2;
   localparam int LINES     = 1 << INDEX_BITS;
   localparam int WORDS     = 1 << WORD_BITS;

   logic [WORD_BITS-1:0]  offset;
   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag;
   logic                  unused_byte_bits;

   assign offset = cpu_addr[WORD_BITS+1:2];
   assign index  = cpu_addr[WORD_BITS+2 +: INDEX_BITS];
   assign tag    = cpu_addr[31 -: TAG_BITS];
   assign unused_byte_bits = ^cpu_addr[1:0];

   state_e                state_q;
   logic [LINE_BITS-1:0]  line_q;
   logic [WORD_BITS-1:0]  cnt_q;
   logic                  req_q;
   logic [31:0]           addr_q;
   logic [31:0]           data_q [LINES][WORDS];

   logic hit;
   logic idle;
   logic miss;
   logic ack;
   logic last;

   assign idle = (state_q == S_IDLE);
   assign miss = idle && !hit;
   // req_q is high exactly in REFILL, so stray acks are dropped here.
   assign ack  = req_q && mem_ack;
   assign last = ack && (cnt_q == WORD_BITS'(WORDS - 1));

   icache_tag_store #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_tags (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (idle),
      .idx_i     (index),
      .tag_i     (tag),
      .clr_en_i  (miss),
      .set_en_i  (last),
      .set_idx_i (line_q[INDEX_BITS-1:0]),
      .set_tag_i (line_q[LINE_BITS-1 -: TAG_BITS]),
      .hit_o     (hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         line_q  <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (!hit) begin
                  state_q <= S_REFILL;
                  line_q  <= cpu_addr[31 -: LINE_BITS];
                  cnt_q   <= '0;
                  req_q   <= 1'b1;
                  addr_q  <= {cpu_addr[31 -: LINE_BITS],
                              {(WORD_BITS+2){1'b0}}};
               end
            end
            S_REFILL: begin
               if (ack) begin
                  cnt_q <= cnt_q + WORD_BITS'(1);
                  if (last) begin
                     state_q <= S_IDLE;
                     req_q   <= 1'b0;
                     addr_q  <= '0;
                  end else begin
                     addr_q  <= addr_q + 32'd4;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ack) data_q[line_q[INDEX_BITS-1:0]][cnt_q] <= mem_rdata;
   end

   assign cpu_inst  = hit ? data_q[index][offset] : NOP;
   assign cpu_stall = !hit;
   assign mem_req   = req_q;
   assign mem_addr  = addr_q;

`ifdef ICACHE_STATS_EN
   logic [31:0] hits_q;
   logic [31:0] misses_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         if (hit)  hits_q   <= hits_q + 32'd1;
         if (miss) misses_q <= misses_q + 32'd1;
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`else
   assign stat_hits   = '0;
   assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus randomized accesses
// checked against a line-address model of a 64-line, 16-byte-line cache.
module tb_icache_dm;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_inst;
   logic        cpu_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;

   int checks   = 0;
   int failures = 0;
   int unsigned cyc = 0;

   bit          mvalid [64];
   logic [31:0] mline  [64];
   int unsigned mhits;
   int unsigned mmisses;
   int unsigned mc;

   icache_dm dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_addr    (cpu_addr),
      .cpu_inst    (cpu_inst),
      .cpu_stall   (cpu_stall),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .stat_hits   (stat_hits),
      .stat_misses (stat_misses)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hA5A5_0F0F ^ {a[15:0], a[31:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic stat_chk(input string tag);
`ifdef ICACHE_STATS_EN
      chk({tag, "_hits"},   stat_hits,   mhits);
      chk({tag, "_misses"}, stat_misses, mmisses);
`else
      chk({tag, "_hits"},   stat_hits,   32'h0);
      chk({tag, "_misses"}, stat_misses, 32'h0);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
      mhits   = 0;
      mmisses = 0;
   endtask

   // One CPU fetch: a hit takes one cycle, a miss runs the whole refill.
   // abort_at >= 0 asserts rst in the first request cycle of that word.
   task automatic access(input logic [31:0] a, input int dly,
                         input int abort_at, output int unsigned miss_cyc);
      logic [31:0] la;
      logic [31:0] base;
      int          idx;
      int          d;
      bit          h;
      cpu_addr = a;
      mem_ack  = 1'b0;
      miss_cyc = 0;
      #1;
      la   = a >> 4;
      base = la << 4;
      idx  = int'(la % 64);
      h    = mvalid[idx] && (mline[idx] == la);
      chk("stall", {31'b0, cpu_stall}, {31'b0, !h});
      chk("inst", cpu_inst, h ? memfn(a & ~32'h3) : 32'h0);
      chk("req_idle", {31'b0, mem_req}, 32'h0);
      if (h) begin
         mhits++;
         tick();
         return;
      end
      mmisses++;
      mvalid[idx] = 1'b0;
      miss_cyc = cyc;
      tick();
      for (int w = 0; w < 4; w++) begin
         if (w == abort_at) begin
            cpu_addr = $urandom;
            mem_ack  = 1'b0;
            rst      = 1'b1;
            #1;
            chk("abort_req", {31'b0, mem_req}, 32'h1);
            chk("abort_addr", mem_addr, base + 32'(w * 4));
            tick();
            rst = 1'b0;
            #1;
            chk("abort_drop", {31'b0, mem_req}, 32'h0);
            chk("abort_stall", {31'b0, cpu_stall}, 32'h1);
            model_clear();
            return;
         end
         d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
         for (int k = 0; k <= d; k++) begin
            cpu_addr  = $urandom;
            mem_ack   = (k == d);
            mem_rdata = mem_ack ? memfn(base + 32'(w * 4)) : $urandom;
            #1;
            chk("req", {31'b0, mem_req}, 32'h1);
            chk("addr", mem_addr, base + 32'(w * 4));
            chk("refill_stall", {31'b0, cpu_stall}, 32'h1);
            chk("refill_inst", cpu_inst, 32'h0);
            tick();
         end
      end
      mem_ack     = 1'b0;
      mvalid[idx] = 1'b1;
      mline[idx]  = la;
   endtask

   initial begin
      rst       = 1'b1;
      cpu_addr  = 32'h0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      model_clear();
      tick();
      tick();
      chk("rst_stall", {31'b0, cpu_stall}, 32'h1);
      chk("rst_req", {31'b0, mem_req}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_inst", cpu_inst, 32'h0);
      chk("rst_hits", stat_hits, 32'h0);
      chk("rst_misses", stat_misses, 32'h0);
      rst = 1'b0;

      // Cold miss with two wait cycles per word, then a hit sweep.
      access(32'h0000_0040, 2, -1, mc);
      access(32'h0000_0040, 0, -1, mc);
      access(32'h0000_0044, 0, -1, mc);
      access(32'h0000_0048, 0, -1, mc);
      access(32'h0000_004C, 0, -1, mc);
      stat_chk("sweep");

      // Same index, different tag evicts; returning misses again.
      access(32'h0000_0440, -1, -1, mc);
      access(32'h0000_0444, 0, -1, mc);
      access(32'h0000_0040, -1, -1, mc);
      access(32'h0000_0048, 0, -1, mc);

      // Back-to-back acks: first hit five cycles after the miss cycle.
      access(32'h0000_1004, 0, -1, mc);
      chk("b2b_lat", cyc - mc, 32'd5);
      access(32'h0000_1000, 0, -1, mc);

      // Reset after two words; line must refill from offset 0.
      access(32'h0000_2008, 1, 2, mc);
      access(32'h0000_2008, 1, -1, mc);
      access(32'h0000_2008, 0, -1, mc);
      access(32'h0000_2000, 0, -1, mc);
      access(32'h0000_200C, 0, -1, mc);
      stat_chk("stats_1m3h");
`ifdef ICACHE_STATS_EN
      chk("stats_m1", stat_misses, 32'd1);
      chk("stats_h3", stat_hits, 32'd3);
`endif

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 1)) << 31) |
             (32'($urandom_range(0, 3)) << 10) |
             (32'($urandom_range(0, 7)) << 4)  |
             (32'($urandom_range(0, 3)) << 2)  |
             32'($urandom_range(0, 3));
         access(a, -1, -1, mc);
      end
      stat_chk("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
